alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 instr_valid  input  1  instruction offered.
REQ-004 instr_ready  output  1  block can accept an instruction.
REQ-005 instr  input  17  [16] imm_sel, [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-006 rsp_valid  output  1  result available.
REQ-007 rsp_ready  input  1  consumer accepts result.
REQ-008 rsp_data  output  8  result byte.
REQ-009 rsp_cout  output  1  carry/shift-out flag.
REQ-010 rsp_err  output  1  divide-by-zero flag.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL hold a 4x8-bit register file R0..R3. Operand a = R[rd]. Operand b = imm if imm_sel=1, else R[rs].
REQ-013 States SHALL be IDLE, EXEC, DIV, RESP.
REQ-014 instr_ready SHALL be 1 only in IDLE.
REQ-015 An instruction is accepted when instr_valid&instr_ready. On acceptance the block SHALL latch op/rd, register a and b, and move to EXEC.
REQ-016 In EXEC, op=3 with b!=0 SHALL go to DIV. All other cases SHALL compute the result and go to RESP.
REQ-017 Op encoding SHALL be:
- 0 add, 1 sub, 2 mul (low byte), 3 div (quotient)
- 4 shl1, 5 shr1, 6 rotl1, 7 rotr1
- 8 and, 9 or, A xor, B nor, C nand, D xnor
- E (a>b ? 1 : 0), F (a==b ? 1 : 0); all comparisons unsigned.
REQ-018 rsp_cout SHALL be:
- add: bit 8 of the 9-bit sum
- sub: borrow (a<b)
- mul: (product[15:8]!=0)
- shl: a[7]; shr: a[0]
- all other ops: 0.
REQ-019 DIV SHALL run an 8-iteration restoring divider, one quotient bit per cycle (8 cycles in DIV), then go to RESP.
REQ-020 Divide with b=0 SHALL skip DIV, give rsp_data=8'hFF and rsp_err=1, and leave R[rd] unchanged.
REQ-021 On entry to RESP the result SHALL be written to R[rd] (except per REQ-020). rsp_data/rsp_cout/rsp_err SHALL stay stable while rsp_valid=1.
REQ-022 rsp_valid SHALL be 1 only in RESP. rsp_valid&rsp_ready SHALL return the block to IDLE; RESP SHALL hold indefinitely otherwise.
REQ-023 Latency, with acceptance in cycle N:
- non-div ops: rsp_valid at N+2
- div with b!=0: rsp_valid at N+10
- earliest next acceptance: the cycle after the response handshake.
REQ-024 instr_valid outside IDLE SHALL be ignored and SHALL NOT be latched.
REQ-025 rd==rs SHALL read the pre-write value of that register.
REQ-026 rsp_err SHALL be 0 for all ops except divide-by-zero.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE and clear R0..R3 to 0.
REQ-028 During reset: instr_ready=0, rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0, busy=0.
REQ-029 Reset mid-operation (EXEC/DIV/RESP) SHALL abort without writeback and without a response.
REQ-030 instr_ready SHALL rise the first cycle after rst_n returns high.

Structure
REQ-031 A shared package alu_pkg SHALL hold the 4-bit op codes, the state enum, and the constants DATA_W=8, NREG=4, DIV_ITER=8.
REQ-032 The single-cycle operations SHALL be a combinational sub-module alu_exec (a, b, op -> res, cout). Divider, FSM and register file SHALL stay in alu_seq.

Verification
REQ-033 Add carry: after reset, R0=8'hC8 via {imm_sel=1, op=9, rd=0, imm=C8}; then {imm_sel=1, op=0, rd=0, imm=64} -> rsp_data=8'h2C, rsp_cout=1, rsp_valid 2 cycles after acceptance, R0=2C.
REQ-034 Divide: R1=8'd200; {imm_sel=1, op=3, rd=1, imm=7} -> rsp_data=28, rsp_cout=0, rsp_err=0, rsp_valid 10 cycles after acceptance.
REQ-035 Divide by zero: {imm_sel=1, op=3, rd=1, imm=0} -> rsp_data=FF, rsp_err=1 at N+2, R1 unchanged.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, instr_ready=0, a pulsed instr_valid is ignored; release -> IDLE next cycle.
REQ-037 Reset in DIV: assert rst_n=0 at the 4th DIV cycle -> no rsp_valid, R0..R3 all 0, instr_ready=1 the cycle after release.
REQ-038 Sweep of all 16 ops (register-register, rd!=rs, random a,b) compared against a reference model for rsp_data/rsp_cout; rotl1 on 8'h81 -> 8'h03.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: datapath sizes, opcode values
// and the controller state encoding.
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int NREG     = 4;
    localparam int DIV_ITER = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROTL = 4'h6;
    localparam logic [3:0] OP_ROTR = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DIV  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction/response handshake bundle between a requester (master) and
// the sequential ALU (slave).
interface alu_seq_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [16:0] instr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_cout;
    logic        rsp_err;
    logic        busy;

    modport master (
        output instr_valid, instr, rsp_ready,
        input  instr_ready, rsp_valid, rsp_data, rsp_cout, rsp_err, busy
    );

    modport slave (
        input  instr_valid, instr, rsp_ready,
        output instr_ready, rsp_valid, rsp_data, rsp_cout, rsp_err, busy
    );

endinterface

// File: rtl/alu_exec.sv
// Single-cycle combinational ALU for every op except the iterative divide;
// the divide slot only supplies the divide-by-zero result.
module alu_exec
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] res_o,
    output logic              cout_o
);

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        prod   = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
        res_o  = '0;
        cout_o = 1'b0;
        case (op_i)
            OP_ADD:  begin res_o = sum[DATA_W-1:0]; cout_o = sum[DATA_W]; end
            OP_SUB:  begin res_o = a_i - b_i; cout_o = (a_i < b_i); end
            OP_MUL:  begin res_o = prod[DATA_W-1:0]; cout_o = |prod[2*DATA_W-1:DATA_W]; end
            OP_DIV:  res_o = '1;
            OP_SHL:  begin res_o = {a_i[DATA_W-2:0], 1'b0}; cout_o = a_i[DATA_W-1]; end
            OP_SHR:  begin res_o = {1'b0, a_i[DATA_W-1:1]}; cout_o = a_i[0]; end
            OP_ROTL: res_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
            OP_ROTR: res_o = {a_i[0], a_i[DATA_W-1:1]};
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NOR:  res_o = ~(a_i | b_i);
            OP_NAND: res_o = ~(a_i & b_i);
            OP_XNOR: res_o = ~(a_i ^ b_i);
            OP_GT:   res_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
            OP_EQ:   res_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: 4-entry register file, accept/execute/respond controller
// and an 8-cycle restoring divider around the combinational alu_exec.
module alu_seq
    import alu_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam int                CNT_W    = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_ITER - 1);

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [1:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   rf_q [NREG];
    logic [DATA_W-1:0]   rf_d [NREG];
    logic [DATA_W-1:0]   res_q, res_d;
    logic                cout_q, cout_d, err_q, err_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                imm_sel;
    logic [3:0]          op_in;
    logic [1:0]          rd_in, rs_in;
    logic [DATA_W-1:0]   imm_in;
    logic                ready;
    logic [DATA_W-1:0]   exec_res;
    logic                exec_cout;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   quo_next;

    assign {imm_sel, op_in, rd_in, rs_in, imm_in} = bus.instr;

    // Handshake outputs are forced low while reset is held, even before the first edge.
    assign ready           = rst_n && (state_q == IDLE);
    assign bus.instr_ready = ready;
    assign bus.rsp_valid   = rst_n && (state_q == RESP);
    assign bus.busy        = rst_n && (state_q != IDLE);
    assign bus.rsp_data    = rst_n ? res_q : '0;
    assign bus.rsp_cout    = rst_n && cout_q;
    assign bus.rsp_err     = rst_n && err_q;

    alu_exec u_exec (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .res_o  (exec_res),
        .cout_o (exec_cout)
    );

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign div_shift = {rem_q, quo_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign quo_next  = {quo_q[DATA_W-2:0], div_ge};

    // Next-state logic; results are committed to the register file on entry to RESP.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        rf_d    = rf_q;
        res_d   = res_q;
        cout_d  = cout_q;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid && ready) begin
                    op_d    = op_in;
                    rd_d    = rd_in;
                    a_d     = rf_q[rd_in];
                    b_d     = imm_sel ? imm_in : rf_q[rs_in];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_DIV && b_q != '0) begin
                    rem_d   = '0;
                    quo_d   = a_q;
                    cnt_d   = '0;
                    state_d = DIV;
                end else begin
                    res_d  = exec_res;
                    cout_d = exec_cout;
                    err_d  = (op_q == OP_DIV);
                    if (op_q != OP_DIV) begin
                        rf_d[rd_q] = exec_res;
                    end
                    state_d = RESP;
                end
            end
            DIV: begin
                rem_d = div_ge ? DATA_W'(div_shift - {1'b0, b_q}) : div_shift[DATA_W-1:0];
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d      = quo_next;
                    cout_d     = 1'b0;
                    err_d      = 1'b0;
                    rf_d[rd_q] = quo_next;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule
